result_transmitter: RTL and testbench

Output-side counterpart of the IO controller's input path. The input path decompresses host data and DMA-writes it into memory; this block DMA-reads CNN result words from memory and serializes each 16-bit word onto the 4-bit `Dout` bus, one nibble per handshake. It raises `interrupt` when transmission begins and pulses `done` when the last nibble has been accepted.

---
 rtl/io_pkg.sv | 17 +
 rtl/nibble_serializer.sv | 50 +++++
 rtl/result_transmitter.sv | 101 ++++++++++
 tb/tb_result_transmitter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO controller input and output paths.
// Holds the transmitter state encoding and the nibble geometry of a word.
package io_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int DATA_W           = 16;
  localparam int NIBBLES_PER_WORD = DATA_W / NIBBLE_W;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT,
    TX_SEND,
    TX_DONE
  } tx_state_t;

endpackage

// File: rtl/nibble_serializer.sv
// Holds one memory word and hands it out MSB nibble first over a valid/ready port.
// last_accepted pulses in the cycle the final nibble of the word is taken.
module nibble_serializer #(
  parameter int DATA_W   = io_pkg::DATA_W,
  parameter int NIBBLE_W = io_pkg::NIBBLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                dout_ready,
  output logic [NIBBLE_W-1:0] dout,
  output logic                dout_valid,
  output logic                last_accepted
);

  localparam int NPW   = DATA_W / NIBBLE_W;
  localparam int CNT_W = (NPW > 1) ? $clog2(NPW) : 1;

  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  nib_cnt;
  logic              valid;
  logic              accept;
  logic              last_nib;

  // Handshake: a nibble moves when dout_valid && dout_ready on a rising edge;
  // while not accepted, dout and dout_valid hold their values.
  assign accept        = valid && dout_ready;
  assign last_nib      = (nib_cnt == CNT_W'(NPW - 1));
  assign last_accepted = accept && last_nib;
  assign dout_valid    = valid;
  assign dout          = valid ? shift[DATA_W-1 -: NIBBLE_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= '0;
      nib_cnt <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      shift   <= load_data;
      nib_cnt <= '0;
      valid   <= 1'b1;
    end else if (accept) begin
      shift   <= shift << NIBBLE_W;
      nib_cnt <= last_nib ? '0 : nib_cnt + 1'b1;
      if (last_nib) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/result_transmitter.sv
// DMA-reads NUM_WORDS result words starting at BASE_ADDR and streams each one
// out as nibbles; interrupt marks the first read, done marks the final nibble.
module result_transmitter #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                NIBBLE_W  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   memAdress,
  output logic                memRead,
  input  logic [DATA_W-1:0]   memData,
  output logic [NIBBLE_W-1:0] Dout,
  output logic                doutValid,
  input  logic                doutReady,
  output logic                interrupt,
  output logic                done,
  output logic                busy,
  output io_pkg::tx_state_t   state_dbg
);

  import io_pkg::*;

  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  tx_state_t         state;
  tx_state_t         state_next;
  logic [ADDR_W-1:0] addr;
  logic [WC_W-1:0]   word_cnt;
  logic              last_word;
  logic              load;
  logic              last_accepted;

  assign last_word = (word_cnt == WC_W'(NUM_WORDS - 1));
  assign state_dbg = state;

  nibble_serializer #(
    .DATA_W   (DATA_W),
    .NIBBLE_W (NIBBLE_W)
  ) u_ser (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .load_data     (memData),
    .dout_ready    (doutReady),
    .dout          (Dout),
    .dout_valid    (doutValid),
    .last_accepted (last_accepted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      addr     <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == TX_IDLE && start) begin
        addr     <= BASE_ADDR;
        word_cnt <= '0;
      end else if (state == TX_SEND && last_accepted && !last_word) begin
        addr     <= addr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    memRead    = 1'b0;
    memAdress  = '0;
    interrupt  = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    busy       = (state != TX_IDLE);
    case (state)
      TX_IDLE: if (start) state_next = TX_REQ;
      TX_REQ: begin
        memRead    = 1'b1;
        memAdress  = addr;
        interrupt  = (word_cnt == '0);
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        // Read data is on memData now, one cycle after the strobe.
        load       = 1'b1;
        state_next = TX_SEND;
      end
      TX_SEND: if (last_accepted) state_next = last_word ? TX_DONE : TX_REQ;
      TX_DONE: begin
        done       = 1'b1;
        state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_transmitter.sv
// Cycle-by-cycle vector bench for result_transmitter over three parameter sets:
// single word at 0, three words at 0x0010, and two words wrapping from 0xFFFF.
module tb_result_transmitter;

  typedef struct {
    string       tag;
    int          dut;
    logic        rst;
    logic        start;
    logic        ready;
    logic [24:0] exp;  // {memRead, interrupt, doutValid, Dout[3:0], done, busy, memAdress[15:0]}
  } vec_t;

  logic               clk;
  logic               rst;
  logic               start_s    [3];
  logic               ready_s    [3];
  logic [15:0]        mem_addr   [3];
  logic               mem_read   [3];
  logic [15:0]        mem_data   [3];
  logic [3:0]         dout       [3];
  logic               dout_valid [3];
  logic               irq        [3];
  logic               done_s     [3];
  logic               busy_s     [3];
  io_pkg::tx_state_t  st         [3];

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  result_transmitter #(.BASE_ADDR(16'h0000), .NUM_WORDS(1)) u_one (
    .clk(clk), .rst(rst), .start(start_s[0]), .memAdress(mem_addr[0]), .memRead(mem_read[0]),
    .memData(mem_data[0]), .Dout(dout[0]), .doutValid(dout_valid[0]), .doutReady(ready_s[0]),
    .interrupt(irq[0]), .done(done_s[0]), .busy(busy_s[0]), .state_dbg(st[0]));

  result_transmitter #(.BASE_ADDR(16'h0010), .NUM_WORDS(3)) u_three (
    .clk(clk), .rst(rst), .start(start_s[1]), .memAdress(mem_addr[1]), .memRead(mem_read[1]),
    .memData(mem_data[1]), .Dout(dout[1]), .doutValid(dout_valid[1]), .doutReady(ready_s[1]),
    .interrupt(irq[1]), .done(done_s[1]), .busy(busy_s[1]), .state_dbg(st[1]));

  result_transmitter #(.BASE_ADDR(16'hFFFF), .NUM_WORDS(2)) u_wrap (
    .clk(clk), .rst(rst), .start(start_s[2]), .memAdress(mem_addr[2]), .memRead(mem_read[2]),
    .memData(mem_data[2]), .Dout(dout[2]), .doutValid(dout_valid[2]), .doutReady(ready_s[2]),
    .interrupt(irq[2]), .done(done_s[2]), .busy(busy_s[2]), .state_dbg(st[2]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models (1-cycle read latency) ----------------
  function automatic logic [15:0] mem_word(input int d, input logic [15:0] a);
    logic [3:0] n;
    n = a[3:0] + 4'd1;
    case (d)
      0:       return (a == 16'h0000) ? 16'hA5C3 : 16'hDEAD;
      1:       return {n, n, n, n};
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      mem_data[i] <= mem_read[i] ? mem_word(i, mem_addr[i]) : 16'hBEEF;
  end

  // ---------------- vector helpers ----------------
  function automatic logic [24:0] e(input logic mr, input logic ir, input logic v,
                                    input logic [3:0] n, input logic dn, input logic b,
                                    input logic [15:0] a);
    return {mr, ir, v, n, dn, b, a};
  endfunction

  function automatic void add(input string tag, input int d, input logic r, input logic s,
                              input logic rd, input logic [24:0] x);
    vec_t v;
    v.tag = tag; v.dut = d; v.rst = r; v.start = s; v.ready = rd; v.exp = x;
    vecs.push_back(v);
  endfunction

  // Full transfer with doutReady held high: start, then per word REQ, WAIT, 4 nibbles.
  function automatic void gen_run(input string tag, input int d, input logic [15:0] base,
                                  input int nw);
    logic [15:0] a;
    logic [15:0] w;
    add(tag, d, 0, 1, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    for (int k = 0; k < nw; k++) begin
      a = base + 16'(k);
      w = mem_word(d, a);
      add(tag, d, 0, 0, 1, e(1, k == 0, 0, 4'h0, 0, 1, a));
      add(tag, d, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 1, 16'h0));
      for (int j = 0; j < 4; j++)
        add(tag, d, 0, 0, 1, e(0, 0, 1, w[15-4*j -: 4], 0, 1, 16'h0));
    end
    add(tag, d, 0, 0, 1, e(0, 0, 0, 4'h0, 1, 1, 16'h0));
    add(tag, d, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
  endfunction

  // ---------------- driver + checker ----------------
  task automatic step(input string tag, input int d, input logic r, input logic s,
                      input logic rd, input logic [24:0] x);
    logic [24:0] got;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    start_s[d] = s;
    ready_s[d] = rd;
    #1;
    got = {mem_read[d], irq[d], dout_valid[d], dout[d], done_s[d], busy_s[d], mem_addr[d]};
    n_total++;
    if (got === x) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %h expected %h (mr,irq,v,dout,done,busy,addr)",
                  tag, d, $time, got, x);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end

    // Reset held 3 cycles (start pulsed on the last one: reset wins), then idle.
    add("reset", 0, 1, 0, 0, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    add("reset", 1, 1, 0, 0, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    add("reset", 2, 1, 1, 0, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    for (int k = 0; k < 6; k++)
      add("idle", k % 3, 0, 0, k % 2, e(0, 0, 0, 4'h0, 0, 0, 16'h0));

    // Single word A5C3, doutReady high: A,5,C,3 on cycles 3-6, done on 7.
    gen_run("single", 0, 16'h0000, 1);

    // Back-pressure: ready low on cycles 3-5 holds Dout=A; done moves to cycle 10.
    add("bp", 0, 0, 1, 0, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    add("bp", 0, 0, 0, 0, e(1, 1, 0, 4'h0, 0, 1, 16'h0000));
    add("bp", 0, 0, 0, 0, e(0, 0, 0, 4'h0, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 0, e(0, 0, 1, 4'hA, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 0, e(0, 0, 1, 4'hA, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 0, e(0, 0, 1, 4'hA, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 1, e(0, 0, 1, 4'hA, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 1, e(0, 0, 1, 4'h5, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 1, e(0, 0, 1, 4'hC, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 1, e(0, 0, 1, 4'h3, 0, 1, 16'h0));
    add("bp", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 1, 1, 16'h0));
    add("bp", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));

    // Three words 1111/2222/3333 at 0x10..0x12: reads on 1,7,13, done on 19.
    gen_run("multi", 1, 16'h0010, 3);

    // Two words from 0xFFFF: second read address wraps to 0x0000.
    gen_run("wrap", 2, 16'hFFFF, 2);

    foreach (vecs[i]) step(vecs[i].tag, vecs[i].dut, vecs[i].rst, vecs[i].start,
                           vecs[i].ready, vecs[i].exp);

    // Ignored start during SEND, then reset mid-word: no done, clean restart at BASE_ADDR.
    step("abort", 0, 0, 1, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    step("abort", 0, 0, 0, 1, e(1, 1, 0, 4'h0, 0, 1, 16'h0000));
    step("abort", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 1, 16'h0));
    step("abort", 0, 0, 0, 1, e(0, 0, 1, 4'hA, 0, 1, 16'h0));
    step("ign_start", 0, 0, 1, 1, e(0, 0, 1, 4'h5, 0, 1, 16'h0));
    step("ign_start", 0, 0, 0, 1, e(0, 0, 1, 4'hC, 0, 1, 16'h0));
    step("abort", 0, 1, 0, 1, e(0, 0, 1, 4'h3, 0, 1, 16'h0));
    step("abort", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    step("abort", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    step("rst_prio", 0, 1, 1, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    step("rst_prio", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    step("restart", 0, 0, 1, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));
    step("restart", 0, 0, 0, 1, e(1, 1, 0, 4'h0, 0, 1, 16'h0000));
    step("restart", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 1, 16'h0));
    step("restart", 0, 0, 0, 1, e(0, 0, 1, 4'hA, 0, 1, 16'h0));
    step("restart", 0, 0, 0, 1, e(0, 0, 1, 4'h5, 0, 1, 16'h0));
    step("restart", 0, 0, 0, 1, e(0, 0, 1, 4'hC, 0, 1, 16'h0));
    step("restart", 0, 0, 0, 1, e(0, 0, 1, 4'h3, 0, 1, 16'h0));
    step("restart", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 1, 1, 16'h0));
    step("restart", 0, 0, 0, 1, e(0, 0, 0, 4'h0, 0, 0, 16'h0));

    // Every FSM rests in IDLE at the end.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (st[i] == io_pkg::TX_IDLE) n_pass++;
      else $display("FAIL final_state dut%0d: got %0d expected %0d", i, st[i], io_pkg::TX_IDLE);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
